// File: rtl/softmc_pkg.sv
// Shared definitions for the SoftMC instruction-sequence receiver:
// END opcode, opcode field position and the receiver state encoding.
package softmc_pkg;

    localparam int          INSTR_W = 32;
    localparam int          OPC_MSB = 31;
    localparam int          OPC_LSB = 28;
    localparam logic [3:0]  OP_END  = 4'b0100;

    typedef enum logic {
        FILL = 1'b0,
        EXEC = 1'b1
    } iseq_state_e;

    // True when the instruction carries the END opcode.
    function automatic logic is_end(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB] == OP_END;
    endfunction

endpackage

// File: rtl/softmc_iseq_receiver_pipe_reg.sv
// One-entry valid/ready register. Accepts a new word whenever it is empty
// or its current word is being taken, so it sustains one word per cycle.
module pipe_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         vld_q;
    logic [W-1:0] data_q;

    assign in_ready_o  = ~vld_q | out_ready_i;
    assign out_valid_o = vld_q;
    assign out_data_o  = data_q;

    // Load a new word when there is room; otherwise hold the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (in_ready_o) begin
            vld_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/softmc_iseq_receiver.sv
// SoftMC instruction-sequence receiver: buffers host instructions until an
// END arrives, then replays the stored sequence in order to the dispatcher.
module softmc_iseq_receiver
    import softmc_pkg::*;
#(
    parameter int ISEQ_AW     = 10,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   app_en,
    input  logic [INSTR_WIDTH-1:0] app_instr,
    output logic                   app_ack,
    output logic                   process_iseq,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic                   iseq_busy,
    output logic                   iseq_overflow
);

    // Highest slot is kept free so an END can always be stored.
    localparam logic [ISEQ_AW-1:0] END_SLOT = '1;

    iseq_state_e         state_q, state_d;
    logic [ISEQ_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ISEQ_AW-1:0]  last_ptr_q, last_ptr_d;
    logic [ISEQ_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic                rd_done_q, rd_done_d;
    logic                ovf_q, ovf_d;

    logic [INSTR_WIDTH-1:0] mem [2**ISEQ_AW];
    logic [INSTR_WIDTH-1:0] ram_data_q;
    logic                   ram_vld_q;

    logic accept;
    logic in_end;
    logic full;
    logic wr_en;
    logic pr_in_ready;
    logic ram_adv;
    logic rd_en;
    logic head_end_taken;

    assign accept         = (state_q == FILL) & app_en;
    assign in_end         = is_end(app_instr);
    assign full           = (wr_ptr_q == END_SLOT);
    assign wr_en          = accept & (in_end | ~full);
    // The RAM output register only moves on when the pipe register can take it.
    assign ram_adv        = ~ram_vld_q | pr_in_ready;
    assign rd_en          = (state_q == EXEC) & ~rd_done_q & ram_adv;
    assign head_end_taken = instr_valid & instr_ready & is_end(instr_data);

    assign app_ack       = accept;
    assign process_iseq  = accept & in_end;
    assign iseq_busy     = (state_q == EXEC);
    assign iseq_overflow = ovf_q;

    // Next-state logic for the FILL/EXEC controller and its pointers.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        last_ptr_d = last_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_done_d  = rd_done_q;
        ovf_d      = ovf_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (in_end) begin
                        last_ptr_d = wr_ptr_q;
                        state_d    = EXEC;
                    end else if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ISEQ_AW'(1);
                    end
                end
            end
            EXEC: begin
                if (rd_en) begin
                    rd_ptr_d = rd_ptr_q + ISEQ_AW'(1);
                    if (rd_ptr_q == last_ptr_q) begin
                        rd_done_d = 1'b1;
                    end
                end
                if (head_end_taken) begin
                    state_d   = FILL;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    rd_done_d = 1'b0;
                    ovf_d     = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Controller state and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            last_ptr_q <= '0;
            rd_ptr_q   <= '0;
            rd_done_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            last_ptr_q <= last_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_done_q  <= rd_done_d;
            ovf_q      <= ovf_d;
        end
    end

    // Simple dual-port buffer with a registered, enabled read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= app_instr;
        end
        if (rd_en) begin
            ram_data_q <= mem[rd_ptr_q];
        end
    end

    // Tracks whether the RAM output register holds an unconsumed entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_vld_q <= 1'b0;
        end else if (ram_adv) begin
            ram_vld_q <= rd_en;
        end
    end

    pipe_reg #(
        .W (INSTR_WIDTH)
    ) u_pipe_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (ram_vld_q),
        .in_ready_o  (pr_in_ready),
        .in_data_i   (ram_data_q),
        .out_valid_o (instr_valid),
        .out_ready_i (instr_ready),
        .out_data_o  (instr_data)
    );

endmodule

// File: tb/tb_softmc_iseq_receiver.sv
// Bench for softmc_iseq_receiver with an 8-entry buffer.
module tb_softmc_iseq_receiver;

    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;
    localparam logic [31:0] END_W = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        app_en;
    logic [31:0] app_instr;
    logic        app_ack;
    logic        process_iseq;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic        iseq_busy;
    logic        iseq_overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] sent_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    bit          exp_ovf;

    logic s_pi;
    int   s_cyc;
    int   first_c, last_c, stab_err, ack_seen;

    softmc_iseq_receiver #(
        .ISEQ_AW     (AW),
        .INSTR_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .app_en        (app_en),
        .app_instr     (app_instr),
        .app_ack       (app_ack),
        .process_iseq  (process_iseq),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .iseq_busy     (iseq_busy),
        .iseq_overflow (iseq_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:28] == 4'h4) w[31:28] = 4'h5;
        return w;
    endfunction

    // Expected replay: non-END words fill at most DEPTH-1 slots, extras are
    // dropped and flagged, the first END closes the sequence.
    function automatic void build_expect();
        exp_q.delete();
        exp_ovf = 0;
        foreach (sent_q[i]) begin
            if (sent_q[i][31:28] == 4'h4) begin
                exp_q.push_back(sent_q[i]);
                break;
            end else if (exp_q.size() < DEPTH - 1) begin
                exp_q.push_back(sent_q[i]);
            end else begin
                exp_ovf = 1;
            end
        end
    endfunction

    function automatic int diff_count();
        int n;
        n = (got_q.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    // Offer one word until acked (bounded); s_pi stays X on timeout.
    task automatic send(input logic [31:0] w);
        app_en    = 1'b1;
        app_instr = w;
        s_pi      = 1'bx;
        s_cyc     = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (app_ack === 1'b1) begin
                s_pi  = process_iseq;
                s_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        app_en = 1'b0;
    endtask

    // Drain the dispatch port until END is taken (bounded).
    // mode 0: ready always, 1: pattern 1,0,0,1, 2: random ready.
    task automatic collect(input int mode);
        logic [31:0] held;
        bit held_v;
        bit done;
        got_q.delete();
        first_c = -1; last_c = -1; stab_err = 0; ack_seen = 0;
        held = '0; held_v = 0; done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            case (mode)
                0:       instr_ready = 1'b1;
                1:       instr_ready = ((i % 4) == 0) || ((i % 4) == 3);
                default: instr_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (app_ack === 1'b1) ack_seen++;
            if (instr_valid === 1'b1) begin
                if (held_v && instr_data !== held) stab_err++;
                if (instr_ready) begin
                    if (first_c < 0) first_c = cyc;
                    last_c = cyc;
                    got_q.push_back(instr_data);
                    held_v = 0;
                    if (instr_data[31:28] == 4'h4) done = 1;
                end else begin
                    held   = instr_data;
                    held_v = 1;
                end
            end
            @(posedge clk); #1;
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; app_en = 1'b0; app_instr = '0; instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (app_ack !== 1'b0) begin bad++; $display("FAIL reset_app_ack got=%b want=0", app_ack); end
        total++; if (process_iseq !== 1'b0) begin bad++; $display("FAIL reset_process_iseq got=%b want=0", process_iseq); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b want=0", instr_valid); end
        total++; if (instr_data !== 32'h0) begin bad++; $display("FAIL reset_instr_data got=%h want=0", instr_data); end
        total++; if (iseq_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", iseq_busy); end
        total++; if (iseq_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", iseq_overflow); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int end_c;
        sent_q = '{32'h1000_0001, 32'h2000_0002, END_W};
        build_expect();
        foreach (sent_q[i]) begin
            send(sent_q[i]);
            total++;
            if (s_pi !== (i == 2)) begin bad++; $display("FAIL basic_pi[%0d] got=%b want=%b", i, s_pi, (i == 2)); end
        end
        end_c = s_cyc;
        total++; if (iseq_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_exec got=%b want=1", iseq_busy); end
        collect(0);
        total++; if (diff_count() != 0) begin bad++; $display("FAIL basic_words got=%0d words want=%0d (diffs=%0d)", got_q.size(), exp_q.size(), diff_count()); end
        total++; if (first_c != end_c + 3) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", first_c, end_c + 3); end
        total++; if (last_c - first_c != 2) begin bad++; $display("FAIL basic_throughput got=%0d want=2", last_c - first_c); end
        @(negedge clk);
        total++; if (iseq_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_fill got=%b want=0", iseq_busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        sent_q = '{32'h1000_0001, 32'h2000_0002, END_W};
        build_expect();
        foreach (sent_q[i]) send(sent_q[i]);
        collect(1);
        total++; if (diff_count() != 0) begin bad++; $display("FAIL bp_words got=%0d words want=%0d (diffs=%0d)", got_q.size(), exp_q.size(), diff_count()); end
        total++; if (stab_err != 0) begin bad++; $display("FAIL bp_stable got=%0d changes want=0", stab_err); end
    endtask

    task automatic test_stall_during_exec();
        logic [31:0] w0, wn;
        w0 = rnd_word();
        wn = rnd_word();
        send(w0);
        total++; if (s_pi !== 1'b0) begin bad++; $display("FAIL stall_pi got=%b want=0", s_pi); end
        send(END_W);
        app_en = 1'b1;
        app_instr = wn;
        collect(0);
        total++; if (ack_seen != 0) begin bad++; $display("FAIL stall_ack_in_exec got=%0d want=0", ack_seen); end
        @(negedge clk);
        total++; if (app_ack !== 1'b1) begin bad++; $display("FAIL stall_ack_after got=%b want=1", app_ack); end
        @(posedge clk); #1;
        app_en = 1'b0;
        sent_q = '{wn, END_W};
        build_expect();
        send(END_W);
        collect(2);
        total++; if (diff_count() != 0) begin bad++; $display("FAIL stall_next_seq got=%0d words want=%0d (diffs=%0d)", got_q.size(), exp_q.size(), diff_count()); end
    endtask

    task automatic test_overflow();
        sent_q.delete();
        for (int i = 0; i < 9; i++) begin
            sent_q.push_back(rnd_word());
            send(sent_q[i]);
            total++;
            if (iseq_overflow !== (i >= DEPTH - 1)) begin
                bad++; $display("FAIL ovf_flag[%0d] got=%b want=%b", i, iseq_overflow, (i >= DEPTH - 1));
            end
        end
        sent_q.push_back(END_W);
        build_expect();
        send(END_W);
        collect(2);
        total++; if (diff_count() != 0 || got_q.size() != 8) begin bad++; $display("FAIL ovf_replay got=%0d words want=8 (diffs=%0d)", got_q.size(), diff_count()); end
        total++; if (stab_err != 0) begin bad++; $display("FAIL ovf_stable got=%0d want=0", stab_err); end
        total++; if (iseq_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", iseq_overflow); end
    endtask

    task automatic test_random();
        int len;
        for (int r = 0; r < 5; r++) begin
            len = $urandom_range(0, 10);
            sent_q.delete();
            for (int i = 0; i < len; i++) sent_q.push_back(rnd_word());
            sent_q.push_back(END_W | ($urandom & 32'h0FFF_FFFF));
            build_expect();
            for (int i = 0; i < len; i++) send(sent_q[i]);
            total++; if (iseq_overflow !== exp_ovf) begin bad++; $display("FAIL rnd%0d_ovf got=%b want=%b", r, iseq_overflow, exp_ovf); end
            send(sent_q[len]);
            collect(2);
            total++; if (diff_count() != 0 || stab_err != 0) begin bad++; $display("FAIL rnd%0d_replay got=%0d words/%0d changes want=%0d words/0", r, got_q.size(), stab_err, exp_q.size()); end
        end
    endtask

    task automatic test_reset_mid_exec();
        bit found;
        sent_q.delete();
        for (int i = 0; i < 5; i++) sent_q.push_back(rnd_word());
        sent_q.push_back(END_W);
        instr_ready = 1'b1;
        foreach (sent_q[i]) send(sent_q[i]);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1 && instr_data === sent_q[2]) found = 1;
        end
        total++; if (!found) begin bad++; $display("FAIL rstmid_reach_entry2 got=0 want=1"); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", instr_valid); end
        total++; if (instr_data !== 32'h0) begin bad++; $display("FAIL rstmid_data got=%h want=0", instr_data); end
        total++; if (iseq_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", iseq_busy); end
        total++; if ({app_ack, process_iseq, iseq_overflow} !== 3'b000) begin bad++; $display("FAIL rstmid_ctrl got=%b want=000", {app_ack, process_iseq, iseq_overflow}); end
        instr_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sent_q = '{END_W};
        build_expect();
        send(END_W);
        total++; if (s_pi !== 1'b1) begin bad++; $display("FAIL rstmid_end_pi got=%b want=1", s_pi); end
        collect(0);
        total++; if (diff_count() != 0) begin bad++; $display("FAIL rstmid_end_only got=%0d words want=1 (diffs=%0d)", got_q.size(), diff_count()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stall_during_exec();
        test_overflow();
        test_random();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
